// File: rtl/token_ring_pkg.sv
// Shared types and helpers for the token-ring arbiter.
// Holds FSM state encoding and the wrap-around token increment.
package token_ring_pkg;

  localparam int TR_MAX_N = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } tr_state_e;

  function automatic logic [3:0] next_pos(
    input logic [3:0] pos,
    input int         n
  );
    return (int'(pos) == n - 1) ? 4'd0 : pos + 4'd1;
  endfunction

endpackage

// File: rtl/token_ring_watchdog.sv
// Hold counter, blocked mask and timeout pulse for the token ring.
// Only instantiated when TOKEN_WATCHDOG_EN is defined.
module token_ring_watchdog
  import token_ring_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_grant,
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_tok,
  output logic                 o_expire,
  output logic [N-1:0]         o_blocked,
  output logic                 o_timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(N);

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_blk;
  logic          r_to;
  logic          w_req_tok;
  logic [N-1:0]  w_tok_oh;

  assign w_req_tok = i_req[i_tok];
  assign o_expire  = i_grant & w_req_tok &
                     (r_cnt == CW'(MAX_HOLD - 1));
  assign o_blocked = r_blk;
  assign o_timeout = r_to;

  always_comb begin
    w_tok_oh = '0;
    for (int k = 0; k < N; k++)
      w_tok_oh[k] = (i_tok == TW'(k));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_blk <= '0;
      r_to  <= 1'b0;
    end else begin
      if (i_grant && w_req_tok && !o_expire)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
      // a low request clears its block; expiry blocks the holder
      r_blk <= (r_blk & i_req) |
               (o_expire ? w_tok_oh : '0);
      r_to  <= o_expire;
    end
  end

endmodule

// File: rtl/token_ring_arbiter.sv
// Clocked token-ring arbiter: one token hop per cycle, 4-phase req/gnt.
// Define TOKEN_WATCHDOG_EN to bound grants to MAX_HOLD cycles.
module token_ring_arbiter
  import token_ring_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] tok_pos_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int TW = $clog2(N);

  if (N < 2 || N > TR_MAX_N) begin : g_bad_n
    $error("token_ring_arbiter: N must be 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("token_ring_arbiter: MAX_HOLD must be >= 2");
  end

  tr_state_e       r_state;
  logic [TW-1:0]   r_tok;
  logic [N-1:0]    r_gnt;
  logic            r_busy;

  logic [TW-1:0]   w_next;
  logic [N-1:0]    w_onehot;
  logic            w_req_tok;
  logic            w_expire;
  logic [N-1:0]    w_blocked;
  logic            w_timeout;

  assign w_next    = TW'(next_pos(4'(r_tok), N));
  assign w_req_tok = req_i[r_tok];

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < N; k++)
      w_onehot[k] = (r_tok == TW'(k));
  end

`ifdef TOKEN_WATCHDOG_EN
  token_ring_watchdog #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_grant   (r_state == GRANT),
    .i_req     (req_i),
    .i_tok     (r_tok),
    .o_expire  (w_expire),
    .o_blocked (w_blocked),
    .o_timeout (w_timeout)
  );
`else
  assign w_expire  = 1'b0;
  assign w_blocked = '0;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tok   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_tok && !w_blocked[r_tok]) begin
            r_state <= GRANT;
            r_gnt   <= w_onehot;
            r_busy  <= 1'b1;
          end else begin
            r_tok   <= w_next;
          end
        end
        GRANT: begin
          if (!w_req_tok || w_expire) begin
            r_state <= RELEASE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        RELEASE: begin
          // one dead cycle so the holder cannot be re-granted
          r_state <= IDLE;
          r_tok   <= w_next;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign tok_pos_o = r_tok;
  assign busy_o    = r_busy;
  assign timeout_o = w_timeout;

endmodule

// File: tb/tb_token_ring_arbiter.sv
// Self-checking bench for token_ring_arbiter (N=4, MAX_HOLD=8).
// Directed scenarios plus randomized 4-phase requesters vs a reference model.
module tb_token_ring_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic [1:0]   tok_pos_o;
  logic         busy_o;
  logic         timeout_o;

  always #5 clk = ~clk;

  token_ring_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .tok_pos_o (tok_pos_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference: token position, current owner (-1 = none),
  // post-release dead cycle, hold length, blocked requesters
  int         m_tok;
  int         m_own;
  int         m_cnt;
  bit         m_rel;
  bit         m_to;
  bit [N-1:0] m_blk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_tok = 0;
    m_own = -1;
    m_cnt = 0;
    m_rel = 1'b0;
    m_to  = 1'b0;
    m_blk = '0;
  endtask

  task automatic m_step(input logic [N-1:0] r);
    bit to;
    to = 1'b0;
    if (m_own >= 0) begin
      if (!r[m_own]) begin
        m_own = -1;
        m_rel = 1'b1;
      end
`ifdef TOKEN_WATCHDOG_EN
      else if (m_cnt == MH - 1) begin
        m_blk[m_own] = 1'b1;
        m_own = -1;
        m_rel = 1'b1;
        to    = 1'b1;
      end
`endif
      else begin
        m_cnt++;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
      m_tok = (m_tok + 1) % N;
    end else if (r[m_tok] && !m_blk[m_tok]) begin
      m_own = m_tok;
      m_cnt = 0;
    end else begin
      m_tok = (m_tok + 1) % N;
    end
    m_blk = m_blk & r;
    m_to  = to;
  endtask

  task automatic compare_all();
    logic [31:0] eg;
    eg = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
    chk("gnt", 32'(gnt_o), eg);
    chk("busy", 32'(busy_o), 32'(m_own >= 0));
    chk("tok", 32'(tok_pos_o), 32'(m_tok));
    chk("timeout", 32'(timeout_o), 32'(m_to));
    chk("onehot0", 32'($onehot0(gnt_o)), 32'd1);
  endtask

  task automatic cyc(input logic [N-1:0] r);
    req_i = r;
    m_step(r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_i = '0;
    @(negedge clk);
    m_reset();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rq;
    int           age [N];
    int           order[$];
    logic [N-1:0] prev;
    int           gcnt;
    int           run;
    int           best;
    int           tos;
    int           exp_order [5];

    // reset values
    reset = 1'b1;
    req_i = '0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_tok", 32'(tok_pos_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);

    // token lap with no requests
    reset = 1'b0;
    chk("lap_tok", 32'(tok_pos_o), 32'd0);
    for (int i = 1; i < 8; i++) begin
      cyc('0);
      chk("lap_tok", 32'(tok_pos_o), 32'(i % N));
      chk("lap_gnt", 32'(gnt_o), 32'd0);
    end

    // single grant to requester 2
    do_reset();
    cyc(4'b0100);
    cyc(4'b0100);
    chk("single_tok2", 32'(tok_pos_o), 32'd2);
    chk("single_pre", 32'(gnt_o), 32'd0);
    cyc(4'b0100);
    chk("single_gnt", 32'(gnt_o), 32'h4);
    cyc(4'b0100);
    chk("single_hold", 32'(gnt_o), 32'h4);
    cyc(4'b0000);
    chk("single_drop", 32'(gnt_o), 32'd0);
    chk("single_rel_tok", 32'(tok_pos_o), 32'd2);
    cyc(4'b0000);
    chk("single_next_tok", 32'(tok_pos_o), 32'd3);

    // contention: all request, each drops 3 cycles after its grant
    do_reset();
    rq   = '1;
    prev = '0;
    for (int k = 0; k < N; k++) age[k] = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(rq);
      if (gnt_o != prev && gnt_o != '0)
        for (int k = 0; k < N; k++)
          if (gnt_o[k]) order.push_back(k);
      prev = gnt_o;
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) begin
          age[k]++;
          if (age[k] == 3) rq[k] = 1'b0;
        end else if (!rq[k]) begin
          rq[k]  = 1'b1;
          age[k] = 0;
        end
      end
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("order_len_ok", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < order.size())
        chk("order", 32'(order[i]), 32'(exp_order[i]));

    // async reset in the middle of a grant
    do_reset();
    cyc(4'b0010);
    cyc(4'b0010);
    chk("mid_gnt", 32'(gnt_o), 32'h2);
    cyc(4'b0010);
    #2 reset = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt_o), 32'd0);
    chk("async_tok", 32'(tok_pos_o), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd0);
    m_reset();
    req_i = '0;
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    for (int i = 1; i < 5; i++) begin
      cyc('0);
      chk("relap_tok", 32'(tok_pos_o), 32'(i % N));
    end

    // requester 1 holds forever
    do_reset();
    gcnt = 0;
    run  = 0;
    best = 0;
    tos  = 0;
    for (int c = 0; c < 102; c++) begin
      cyc(4'b0010);
      if (gnt_o[1]) begin
        gcnt++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (timeout_o) tos++;
    end
`ifdef TOKEN_WATCHDOG_EN
    chk("wd_gnt_cycles", 32'(gcnt), 32'(MH));
    chk("wd_run", 32'(best), 32'(MH));
    chk("wd_pulses", 32'(tos), 32'd1);
    cyc(4'b0000);
    gcnt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(4'b0010);
      if (gnt_o[1]) gcnt++;
    end
    chk("wd_unblocked", 32'(gcnt > 0), 32'd1);
`else
    chk("hold_gnt_cycles", 32'(gcnt), 32'd101);
    chk("hold_run", 32'(best), 32'd101);
    chk("hold_no_timeout", 32'(tos), 32'd0);
`endif

    // randomized 4-phase requesters
    do_reset();
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      cyc(rq);
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) begin
          if ($urandom_range(3) == 0) rq[k] = 1'b0;
        end else if (rq[k]) begin
          if ($urandom_range(15) == 0) rq[k] = 1'b0;
        end else begin
          if ($urandom_range(2) == 0) rq[k] = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
